// File: rtl/zero_cross_detector_pkg.sv
// Shared types and helpers for the tuner front end: sample width, handshake FSM states
// and the saturating narrowing used after DC removal.
package zero_cross_detector_pkg;

    localparam int SAMPLE_W = 24;

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_ACK  = 2'd1,
        S_PROC = 2'd2
    } state_t;

    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = {1'b0, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = {1'b1, {(SAMPLE_W-1){1'b0}}};

    // One guard bit is enough: the input is always a difference of two SAMPLE_W values.
    function automatic logic signed [SAMPLE_W-1:0] sat_to_w(input logic signed [SAMPLE_W:0] v);
        if (v[SAMPLE_W] != v[SAMPLE_W-1]) begin
            return v[SAMPLE_W] ? SAMPLE_MIN : SAMPLE_MAX;
        end
        return v[SAMPLE_W-1:0];
    endfunction

endpackage

// File: rtl/zero_cross_detector_if.sv
// Codec FIFO read port: the detector (master) pops samples from the audio codec (slave).
interface zero_cross_detector_if;
    import zero_cross_detector_pkg::*;

    logic                read_ready;
    logic [SAMPLE_W-1:0] readdata_left;
    logic                read;

    modport master (
        input  read_ready,
        input  readdata_left,
        output read
    );

    modport slave (
        output read_ready,
        output readdata_left,
        input  read
    );

endinterface

// File: rtl/zero_cross_detector_dc.sv
// Leaky-integrator DC tracker: acc converges to x * 2^DC_SHIFT, so acc >>> DC_SHIFT is the
// running mean. centred_o is combinational from the current sample and the stored accumulator.
module zero_cross_detector_dc
    import zero_cross_detector_pkg::*;
#(
    parameter int DC_SHIFT = 10
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       update_i,
    input  logic signed [SAMPLE_W-1:0] x_i,
    output logic signed [SAMPLE_W-1:0] centred_o
);

    generate
        if (DC_SHIFT > 0) begin : g_track
            localparam int ACC_W = SAMPLE_W + DC_SHIFT;

            logic signed [ACC_W-1:0]    acc_q;
            logic signed [ACC_W-1:0]    acc_d;
            logic signed [SAMPLE_W-1:0] dc;
            logic signed [SAMPLE_W:0]   diff;

            assign dc        = acc_q[ACC_W-1:DC_SHIFT];
            assign acc_d     = acc_q + ACC_W'(x_i) - ACC_W'(dc);
            assign diff      = (SAMPLE_W+1)'(x_i) - (SAMPLE_W+1)'(dc);
            assign centred_o = sat_to_w(diff);

            always_ff @(posedge clk) begin
                if (reset) begin
                    acc_q <= '0;
                end else if (update_i) begin
                    acc_q <= acc_d;
                end
            end
        end else begin : g_bypass
            logic unused_bypass;
            assign unused_bypass = ^{clk, reset, update_i};
            assign centred_o     = x_i;
        end
    endgenerate

endmodule

// File: rtl/zero_cross_detector.sv
// Tuner front end: pops codec samples, removes DC, derives a hysteretic sign bit and pulses
// once per qualified rising (negative-to-positive) crossing.
module zero_cross_detector
    import zero_cross_detector_pkg::*;
#(
    parameter int HYST     = 16384,
    parameter int DC_SHIFT = 10,
    parameter int MIN_GAP  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    zero_cross_detector_if.master codec,
    output logic                  sample_tick,
    output logic                  sign_out,
    output logic                  cross_pulse,
    output logic [SAMPLE_W-1:0]   centred_sample
);

    localparam int GAP_W = $clog2(MIN_GAP + 1);
    localparam logic signed [SAMPLE_W-1:0] HYST_POS = SAMPLE_W'(HYST);
    localparam logic signed [SAMPLE_W-1:0] HYST_NEG = -HYST_POS;
    localparam logic [GAP_W-1:0]           GAP_MAX  = GAP_W'(MIN_GAP);

    state_t                     state_q;
    logic signed [SAMPLE_W-1:0] sample_q;
    logic signed [SAMPLE_W-1:0] centred_q;
    logic signed [SAMPLE_W-1:0] centred;
    logic                       read_q;
    logic                       tick_q;
    logic                       sign_q;
    logic                       cross_q;
    logic [GAP_W-1:0]           gap_q;

    logic                       process;
    logic                       sign_d;
    logic                       rising;
    logic [GAP_W-1:0]           gap_d;

    // Results are committed on the edge leaving S_ACK so they are visible during S_PROC.
    assign process = (state_q == S_ACK) && enable;

    zero_cross_detector_dc #(
        .DC_SHIFT (DC_SHIFT)
    ) u_dc (
        .clk       (clk),
        .reset     (reset),
        .update_i  (process),
        .x_i       (sample_q),
        .centred_o (centred)
    );

    always_comb begin
        sign_d = sign_q;
        if (centred > HYST_POS) begin
            sign_d = 1'b0;
        end else if (centred < HYST_NEG) begin
            sign_d = 1'b1;
        end
        gap_d  = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;
        rising = sign_q && !sign_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_WAIT;
            sample_q  <= '0;
            read_q    <= 1'b0;
            tick_q    <= 1'b0;
            sign_q    <= 1'b0;
            cross_q   <= 1'b0;
            centred_q <= '0;
            gap_q     <= GAP_MAX;
        end else begin
            read_q  <= 1'b0;
            tick_q  <= 1'b0;
            cross_q <= 1'b0;
            case (state_q)
                S_WAIT: begin
                    if (codec.read_ready) begin
                        sample_q <= codec.readdata_left;
                        read_q   <= 1'b1;
                        state_q  <= S_ACK;
                    end
                end
                S_ACK: begin
                    state_q <= S_PROC;
                    if (enable) begin
                        tick_q    <= 1'b1;
                        centred_q <= centred;
                        sign_q    <= sign_d;
                        // A too-early crossing still moves the sign but keeps the gap running.
                        if (rising && (gap_d >= GAP_MAX)) begin
                            cross_q <= 1'b1;
                            gap_q   <= '0;
                        end else begin
                            gap_q   <= gap_d;
                        end
                    end
                end
                S_PROC: state_q <= S_WAIT;
                default: state_q <= S_WAIT;
            endcase
        end
    end

    assign codec.read     = read_q;
    assign sample_tick    = tick_q;
    assign sign_out       = sign_q;
    assign cross_pulse    = cross_q;
    assign centred_sample = centred_q;

endmodule
